// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch-control select encoding, fetch FSM states, datapath width.
package cpu_pkg;

    localparam int XLEN = 32;

    // Branch_Control select encoding, shared with the branch control unit in EX.
    localparam logic [1:0] BC_PC4 = 2'd0;
    localparam logic [1:0] BC_IMM = 2'd1;
    localparam logic [1:0] BC_ALU = 2'd2;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/pc_target_calc.sv
// Redirect target selection: branch/JALR target mux, JALR LSB clear,
// alignment check and trap-vector substitution.
module pc_target_calc
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] TRAP_VECTOR = 32'h0000_0100
) (
    input  logic [1:0]      Branch_Control,
    input  logic [XLEN-1:0] branch_pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_result,
    output logic            redirect,
    output logic [XLEN-1:0] raw_target,
    output logic [XLEN-1:0] target,
    output logic            misaligned
);

    // Select the raw target; reserved code 3 behaves as sequential (no redirect).
    always_comb begin
        redirect   = 1'b0;
        raw_target = '0;
        case (Branch_Control)
            BC_IMM: begin
                redirect   = 1'b1;
                raw_target = branch_pc + imm;
            end
            BC_ALU: begin
                redirect   = 1'b1;
                raw_target = alu_result & {{(XLEN-1){1'b1}}, 1'b0};
            end
            default: ;
        endcase
        misaligned = redirect && (raw_target[1:0] != 2'b00);
        target     = misaligned ? TRAP_VECTOR : raw_target;
    end

endmodule

// File: rtl/next_pc_unit.sv
// IF-stage program counter and fetch-request controller. Streams sequential
// fetches, holds on stall, redirects on taken branches/jumps, and drains an
// in-flight fetch before switching to a redirect target.
module next_pc_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      Branch_Control,
    input  logic [XLEN-1:0] branch_pc,
    input  logic [XLEN-1:0] imm,
    input  logic [XLEN-1:0] alu_result,
    input  logic            stall,
    input  logic            imem_ready,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    output logic            instr_valid,
    output logic [XLEN-1:0] fetch_pc,
    output logic            flush,
    output logic            misaligned_exc,
    output logic [XLEN-1:0] misaligned_addr
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pending;
    logic [XLEN-1:0] mis_addr_q;

    logic            redirect;
    logic            misaligned;
    logic [XLEN-1:0] raw_target;
    logic [XLEN-1:0] target;
    logic            active;

    pc_target_calc #(
        .TRAP_VECTOR(TRAP_VECTOR)
    ) u_target (
        .Branch_Control(Branch_Control),
        .branch_pc     (branch_pc),
        .imm           (imm),
        .alu_result    (alu_result),
        .redirect      (redirect),
        .raw_target    (raw_target),
        .target        (target),
        .misaligned    (misaligned)
    );

    // A redirect only counts once a fetch stream exists (FETCH or DRAIN).
    assign active          = !rst && (state != BOOT);
    assign imem_req        = active;
    // pc is not advanced while draining, so the in-flight address stays put.
    assign imem_addr       = pc;
    assign flush           = active && redirect;
    assign misaligned_exc  = flush && misaligned;
    assign misaligned_addr = misaligned_exc ? raw_target : mis_addr_q;
    // Redirect kills the delivered word, so valid and flush never coincide.
    assign instr_valid     = !rst && (state == FETCH) && imem_ready && !stall && !redirect;
    assign fetch_pc        = instr_valid ? pc : '0;

    // Fetch FSM, PC register, pending redirect target and exception address.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= BOOT;
            pc         <= RESET_VECTOR;
            pending    <= '0;
            mis_addr_q <= '0;
        end else begin
            if (misaligned_exc)
                mis_addr_q <= raw_target;
            case (state)
                BOOT: begin
                    pc    <= RESET_VECTOR;
                    state <= FETCH;
                end
                FETCH: begin
                    if (redirect) begin
                        if (imem_ready) begin
                            pc <= target;
                        end else begin
                            pending <= target;
                            state   <= DRAIN;
                        end
                    end else if (imem_ready && !stall) begin
                        pc <= pc + XLEN'(4);
                    end
                end
                DRAIN: begin
                    // Latest redirect wins; the drained word is discarded.
                    if (redirect)
                        pending <= target;
                    if (imem_ready) begin
                        pc    <= redirect ? target : pending;
                        state <= FETCH;
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: doc/next_pc_unit.md
Name: next_pc_unit

Overview:
- Owns the program counter and the instruction-fetch request. It consumes the 2-bit Branch_Control select that the branch control unit produces in EX, using the same encoding: 0 = PC+4, 1 = PC+imm, 2 = ALU_Result.
- Computes the redirect target, handles the instruction-memory fetch handshake, holds the PC during stalls, and pulses flush to IF/ID and ID/EX on every redirect.
- Sits in the IF stage of the five-stage CPU.

Parameters:
- RESET_VECTOR, 32'h0000_0000, first fetch address after reset.
- TRAP_VECTOR, 32'h0000_0100, redirect address when a target is misaligned.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- Branch_Control  in  2  0 = PC+4, 1 = PC+imm, 2 = ALU_Result, 3 = reserved (treated as 0).
- branch_pc  in  32  PC of the EX-stage instruction.
- imm  in  32  sign-extended immediate of the EX-stage instruction.
- alu_result  in  32  JALR sum rs1+imm.
- stall  in  1  load-use hold request from hazard unit.
- imem_ready  in  1  instruction memory delivers data for imem_addr this cycle.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address; stable while imem_req=1 and imem_ready=0.
- instr_valid  out  1  delivered instruction is to be latched into IF/ID.
- fetch_pc  out  32  PC of the delivered instruction.
- flush  out  1  one-cycle pulse: kill IF/ID and ID/EX.
- misaligned_exc  out  1  one-cycle pulse: target misaligned.
- misaligned_addr  out  32  offending target; held until the next exception.

Behaviour:
- Target computation (combinational):
  - BC=1 → branch_pc+imm.
  - BC=2 → alu_result & ~32'h1.
  - All adds are modulo 2^32; PC+4 from 32'hFFFF_FFFC wraps to 0.
  - If target[1:0] != 0, the redirect goes to TRAP_VECTOR instead, misaligned_exc pulses, and misaligned_addr captures the target.
- States:
  - BOOT: imem_req=0. Next cycle go to FETCH with pc=RESET_VECTOR.
  - FETCH: imem_req=1, imem_addr=pc.
  - DRAIN: imem_req=1, imem_addr=old pc; waiting to discard an in-flight fetch.
- Reset: state=BOOT, pc=RESET_VECTOR, pending=0. All outputs 0 except imem_addr=RESET_VECTOR. Reset wins over every other input in any state, including DRAIN; the pending target is dropped.
- FETCH, no redirect:
  - imem_ready & ~stall: instr_valid=1, fetch_pc=pc, pc<=pc+4. Next request is issued the following cycle, so zero-bubble streaming holds when ready is 1 every cycle.
  - imem_ready & stall: instr_valid=0, pc held, imem_req stays 1; memory redelivers the same word.
  - ~imem_ready: instr_valid=0, pc held.
- FETCH, redirect (BC in {1,2}); redirect has priority over stall:
  - flush=1 that cycle and instr_valid=0.
  - If imem_ready=1 or the request was issued this cycle with ready=0 pending: when ready=1, pc<=target and stay in FETCH.
  - If ready=0, latch target into pending and go to DRAIN; the address is not changed mid-transaction.
- DRAIN:
  - On imem_ready: discard the data (instr_valid=0), pc<=pending, go to FETCH.
  - A further redirect while in DRAIN overwrites pending and pulses flush again.
  - stall is ignored in DRAIN.
- Latency:
  - Redirect with ready=1: target appears on imem_addr the next cycle.
  - Redirect into DRAIN: target appears on imem_addr the cycle after the draining ready.
- instr_valid is never 1 in the same cycle as flush.

Decomposition:
- Shared package (cpu_pkg): BC_PC4=2'd0, BC_IMM=2'd1, BC_ALU=2'd2 (shared with the branch control unit), the fetch state enum {BOOT, FETCH, DRAIN}, and XLEN=32.
- One sub-module, pc_target_calc: combinational target mux, JALR LSB clear, misalignment check, trap substitution.
- The state machine and PC register live in next_pc_unit.

Test Plan:
- Reset and boot: hold rst 3 cycles, then release; ready=1 every cycle → imem_req=0 during reset and BOOT; imem_addr sequence 0x0, 0x4, 0x8; instr_valid=1 each cycle with fetch_pc matching.
- Taken branch: BC=1, branch_pc=0x10, imm=32'hFFFF_FFF8, ready=1 → flush=1 for one cycle, instr_valid=0 that cycle; next imem_addr=0x08.
- JALR targets: BC=2, alu_result=0x201 → next addr 0x200, no exception. Then alu_result=0x206 → misaligned_exc=1, misaligned_addr=0x206, next addr 0x100.
- Redirect in flight: ready=0 at imem_addr=0x20 when BC=1 gives target 0x80 → imem_addr stays 0x20; ready rises 2 cycles later with instr_valid=0; next addr 0x80.
- Stall and wrap: stall=1 for 3 cycles with ready=1 at pc=0x40 → pc held, instr_valid=0 for 3 cycles, then fetch_pc=0x40. Separately, pc=0xFFFF_FFFC fetched → next addr 0x0.
- Reset in DRAIN: assert rst while in DRAIN with pending=0x80 → next cycle state=BOOT, imem_req=0; first fetch goes to 0x0, not 0x80.
